// File: rtl/id_ex_pipeline_reg.sv
// id_ex_pipeline_reg: ID->EX pipeline register with load-use hazard detection and bubble insertion.
// Ports: clk; rst (async, active-low); *D decode-stage controls/operands/indices; PCSrcE (branch taken in EX);
//        *_E registered execute-stage copies; ValidE (0 = bubble); StallF/StallD/FlushD hazard controls.
// Optional: define ID_EX_PERF_CNT_EN to add BubbleCnt/FlushCnt (load-use bubbles, branch flushes).
module id_ex_pipeline_reg #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWriteD,
    input  logic              MemWriteD,
    input  logic              ResultSrcD,
    input  logic              ALUSrcD,
    input  logic              BranchD,
    input  logic [2:0]        ALUControlD,
    input  logic [XLEN-1:0]   RD1_D,
    input  logic [XLEN-1:0]   RD2_D,
    input  logic [XLEN-1:0]   Imm_Ext_D,
    input  logic [XLEN-1:0]   PCD,
    input  logic [XLEN-1:0]   PCPlus4D,
    input  logic [REG_AW-1:0] RS1_D,
    input  logic [REG_AW-1:0] RS2_D,
    input  logic [REG_AW-1:0] RD_D,
    input  logic              PCSrcE,
    output logic              RegWriteE,
    output logic              MemWriteE,
    output logic              ResultSrcE,
    output logic              ALUSrcE,
    output logic              BranchE,
    output logic [2:0]        ALUControlE,
    output logic [XLEN-1:0]   RD1_E,
    output logic [XLEN-1:0]   RD2_E,
    output logic [XLEN-1:0]   Imm_Ext_E,
    output logic [XLEN-1:0]   PCE,
    output logic [XLEN-1:0]   PCPlus4E,
    output logic [REG_AW-1:0] Rs1_E,
    output logic [REG_AW-1:0] Rs2_E,
    output logic [REG_AW-1:0] RD_E,
    output logic              ValidE,
`ifdef ID_EX_PERF_CNT_EN
    output logic [31:0]       BubbleCnt,
    output logic [31:0]       FlushCnt,
`endif
    output logic              StallF,
    output logic              StallD,
    output logic              FlushD
);
    typedef struct packed {
        logic              rw;
        logic              mw;
        logic              rsrc;
        logic              alusrc;
        logic              br;
        logic [2:0]        aluc;
        logic [XLEN-1:0]   rd1;
        logic [XLEN-1:0]   rd2;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   pc4;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
    } ex_t;
    ex_t  ex_q, ex_d;
    logic valid_q, valid_d;
    logic lu;
    // A valid load in EX writing a non-x0 register that D reads (either source, used or not).
    assign lu = valid_q & ex_q.rsrc & ex_q.rw & (ex_q.rd != '0) & ((ex_q.rd == RS1_D) | (ex_q.rd == RS2_D));
    // Flush wins over stall: the D instruction is wrong-path, so holding it would be pointless.
    assign StallF = rst & lu & ~PCSrcE;
    assign StallD = rst & lu & ~PCSrcE;
    assign FlushD = rst & PCSrcE;
    assign valid_d = ~(PCSrcE | lu);
    assign ex_d = valid_d ? {RegWriteD, MemWriteD, ResultSrcD, ALUSrcD, BranchD, ALUControlD,
                             RD1_D, RD2_D, Imm_Ext_D, PCD, PCPlus4D, RS1_D, RS2_D, RD_D} : '0;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            ex_q    <= ex_d;
            valid_q <= valid_d;
        end
    end
    assign {RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE, ALUControlE,
            RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, Rs1_E, Rs2_E, RD_E} = ex_q;
    assign ValidE = valid_q;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bub_q, fl_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bub_q <= '0;
            fl_q  <= '0;
        end else if (PCSrcE) begin
            fl_q  <= fl_q + 32'd1;
        end else if (lu) begin
            bub_q <= bub_q + 32'd1;
        end
    end
    assign BubbleCnt = bub_q;
    assign FlushCnt  = fl_q;
`endif
endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// tb_id_ex_pipeline_reg: table vectors, directed hazard sequences and random stimulus against a reference model.
module tb_id_ex_pipeline_reg;
    typedef struct packed {
        logic        rw;
        logic        mw;
        logic        rsrc;
        logic        alusrc;
        logic        br;
        logic [2:0]  aluc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } dv_t;
    typedef struct {
        logic       p_load;
        logic       p_rw;
        logic [4:0] p_rd;
        logic [4:0] c_rs1;
        logic [4:0] c_rs2;
        logic [4:0] c_rd;
        logic       pc;
        logic       e_stall;
        logic       e_flush;
        logic       e_valid;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic PCSrcE = 1'b0;
    dv_t  d, e_act, m_e;
    logic m_v = 1'b0;
    int   total = 0;
    int   bad = 0;
    logic RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE, ValidE, StallF, StallD, FlushD;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
    logic [4:0]  Rs1_E, Rs2_E, RD_E;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] BubbleCnt, FlushCnt;
    logic [31:0] m_bub = 0;
    logic [31:0] m_fl = 0;
`endif
    vec_t tv[8];

    always #5 clk = ~clk;

    id_ex_pipeline_reg dut (
        .clk(clk), .rst(rst),
        .RegWriteD(d.rw), .MemWriteD(d.mw), .ResultSrcD(d.rsrc), .ALUSrcD(d.alusrc), .BranchD(d.br),
        .ALUControlD(d.aluc), .RD1_D(d.rd1), .RD2_D(d.rd2), .Imm_Ext_D(d.imm), .PCD(d.pc), .PCPlus4D(d.pc4),
        .RS1_D(d.rs1), .RS2_D(d.rs2), .RD_D(d.rd), .PCSrcE(PCSrcE),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE), .ALUSrcE(ALUSrcE), .BranchE(BranchE),
        .ALUControlE(ALUControlE), .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .Rs1_E(Rs1_E), .Rs2_E(Rs2_E), .RD_E(RD_E), .ValidE(ValidE),
`ifdef ID_EX_PERF_CNT_EN
        .BubbleCnt(BubbleCnt), .FlushCnt(FlushCnt),
`endif
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD)
    );

    assign e_act = {RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE, ALUControlE,
                    RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, Rs1_E, Rs2_E, RD_E};

    function automatic dv_t rnd();
        logic [191:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return t[182:0];
    endfunction

    task automatic chk(input string n, input logic [255:0] a, input logic [255:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", n, a, e);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        rst = 1'b1;
        m_e = '0;
        m_v = 1'b0;
`ifdef ID_EX_PERF_CNT_EN
        m_bub = 0;
        m_fl = 0;
`endif
    endtask

    // One clock: check the hazard outputs the model predicts for the current E/D contents,
    // then apply the edge rules (reset, flush, load-use bubble, capture) and check the EX slot.
    task automatic step(input string t);
        logic lu;
        #1;
        lu = rst && m_v && m_e.rsrc && m_e.rw && (m_e.rd != 0) && (m_e.rd == d.rs1 || m_e.rd == d.rs2);
        chk({t, ".StallF"}, StallF, lu && !PCSrcE);
        chk({t, ".StallD"}, StallD, lu && !PCSrcE);
        chk({t, ".FlushD"}, FlushD, rst && PCSrcE);
        @(posedge clk);
        if (!rst) begin
            m_e = '0;
            m_v = 1'b0;
`ifdef ID_EX_PERF_CNT_EN
            m_bub = 0;
            m_fl = 0;
`endif
        end else if (PCSrcE || lu) begin
            m_e = '0;
            m_v = 1'b0;
`ifdef ID_EX_PERF_CNT_EN
            if (PCSrcE) m_fl = m_fl + 1;
            else m_bub = m_bub + 1;
`endif
        end else begin
            m_e = d;
            m_v = 1'b1;
        end
        #1;
        chk({t, ".E"}, e_act, m_e);
        chk({t, ".ValidE"}, ValidE, m_v);
`ifdef ID_EX_PERF_CNT_EN
        chk({t, ".BubbleCnt"}, BubbleCnt, m_bub);
        chk({t, ".FlushCnt"}, FlushCnt, m_fl);
`endif
    endtask

    initial begin
        tv[0] = '{1, 1, 6, 6, 1, 7, 0, 1, 0, 0};
        tv[1] = '{1, 1, 6, 1, 6, 7, 0, 1, 0, 0};
        tv[2] = '{1, 1, 0, 0, 0, 3, 0, 0, 0, 1};
        tv[3] = '{0, 1, 6, 6, 1, 7, 0, 0, 0, 1};
        tv[4] = '{1, 0, 6, 6, 1, 7, 0, 0, 0, 1};
        tv[5] = '{1, 1, 6, 6, 1, 7, 1, 0, 1, 0};
        tv[6] = '{1, 1, 6, 2, 3, 7, 1, 0, 1, 0};
        tv[7] = '{1, 1, 6, 2, 3, 7, 0, 0, 0, 1};

        // Reset with random D and a taken branch: nothing may leak out
        d = rnd();
        PCSrcE = 1'b1;
        step("t1_rst0");
        chk("t1.FlushD_in_reset", FlushD, 0);
        d = rnd();
        step("t1_rst1");
        PCSrcE = 1'b0;
        rst = 1'b1;
        d = rnd();
        step("t1_release");
        chk("t1.capture_valid", ValidE, 1);
        chk("t1.capture_pc", PCE, d.pc);

        // Pass-through
        do_reset();
        d = rnd();
        d.rd = 5;
        d.rw = 1;
        d.rd1 = 32'h1234;
        step("t2");
        chk("t2.RD_E", RD_E, 5);
        chk("t2.RD1_E", RD1_E, 32'h1234);

        // Table vectors: previous instruction into E, then the D instruction under test
        for (int i = 0; i < 8; i++) begin
            do_reset();
            d = rnd();
            d.rsrc = tv[i].p_load;
            d.rw = tv[i].p_rw;
            d.rd = tv[i].p_rd;
            PCSrcE = 1'b0;
            step("vec_prior");
            d = rnd();
            d.rs1 = tv[i].c_rs1;
            d.rs2 = tv[i].c_rs2;
            d.rd = tv[i].c_rd;
            PCSrcE = tv[i].pc;
            #1;
            chk($sformatf("vec%0d.stall", i), StallF, tv[i].e_stall);
            chk($sformatf("vec%0d.flush", i), FlushD, tv[i].e_flush);
            step("vec_cur");
            chk($sformatf("vec%0d.valid", i), ValidE, tv[i].e_valid);
            chk($sformatf("vec%0d.RD_E", i), RD_E, tv[i].e_valid ? tv[i].c_rd : 5'd0);
        end
        PCSrcE = 1'b0;

        // Load-use: lw x6 then add x7,x6,x1 -> one bubble, then the add enters EX
        do_reset();
        d = rnd();
        d.rsrc = 1; d.rw = 1; d.rd = 6;
        step("t3_lw");
        d = rnd();
        d.rsrc = 0; d.rw = 1; d.rd = 7; d.rs1 = 6; d.rs2 = 1;
        #1;
        chk("t3.stall_on", StallF, 1);
        step("t3_bubble");
        chk("t3.bubble_valid", ValidE, 0);
        #1;
        chk("t3.stall_off", StallD, 0);
        step("t3_reenter");
        chk("t3.Rs1_E", Rs1_E, 6);
        chk("t3.valid", ValidE, 1);

        // Reset asserted mid-stall clears at once; first cycle after release captures
        do_reset();
        d = rnd();
        d.rsrc = 1; d.rw = 1; d.rd = 6;
        step("rs_lw");
        d = rnd();
        d.rsrc = 0; d.rs1 = 6; d.rs2 = 2;
        #1;
        chk("rs.stall_on", StallF, 1);
        rst = 1'b0;
        #1;
        chk("rs.stall_async", StallF, 0);
        chk("rs.valid_async", ValidE, 0);
        chk("rs.rd_async", RD_E, 0);
        step("rs_held");
        rst = 1'b1;
        step("rs_release");
        chk("rs.capture", Rs1_E, 6);

        // Taken branch alongside a load-use: flush wins
        do_reset();
        d = rnd();
        d.rsrc = 1; d.rw = 1; d.rd = 6;
        step("t5_lw");
        d = rnd();
        d.rs1 = 6;
        PCSrcE = 1'b1;
        #1;
        chk("t5.FlushD", FlushD, 1);
        chk("t5.StallF", StallF, 0);
        step("t5_flush");
        chk("t5.RegWriteE", RegWriteE, 0);
        chk("t5.MemWriteE", MemWriteE, 0);
        PCSrcE = 1'b0;

`ifdef ID_EX_PERF_CNT_EN
        do_reset();
        for (int i = 0; i < 3; i++) begin
            d = rnd();
            d.rsrc = 1; d.rw = 1; d.rd = 9;
            step("t6_lw");
            d = rnd();
            d.rsrc = 0; d.rs2 = 9;
            step("t6_bubble");
            step("t6_dep");
        end
        PCSrcE = 1'b1;
        step("t6_fl");
        step("t6_fl");
        PCSrcE = 1'b0;
        chk("t6.BubbleCnt", BubbleCnt, 3);
        chk("t6.FlushCnt", FlushCnt, 2);
        force dut.bub_q = 32'hFFFF_FFFF;
        force dut.fl_q = 32'hFFFF_FFFF;
        #1;
        release dut.bub_q;
        release dut.fl_q;
        m_bub = 32'hFFFF_FFFF;
        m_fl = 32'hFFFF_FFFF;
        d = rnd();
        d.rsrc = 1; d.rw = 1; d.rd = 9;
        step("t6_wlw");
        d = rnd();
        d.rsrc = 0; d.rs1 = 9;
        step("t6_wbub");
        chk("t6.bub_wrap", BubbleCnt, 0);
        PCSrcE = 1'b1;
        step("t6_wfl");
        chk("t6.fl_wrap", FlushCnt, 0);
        PCSrcE = 1'b0;
`endif

        // Random traffic with small register indices so hazards are frequent
        do_reset();
        for (int i = 0; i < 400; i++) begin
            d = rnd();
            d.rd = 5'($urandom_range(0, 3));
            d.rs1 = 5'($urandom_range(0, 3));
            d.rs2 = 5'($urandom_range(0, 3));
            PCSrcE = ($urandom_range(0, 5) == 0);
            rst = ($urandom_range(0, 40) != 0);
            step("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
